// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      if_req;
    logic [ADDR_WIDTH-1:0]     if_addr;
    logic                      if_gnt;
    logic                      if_rvalid;
    logic [DATA_WIDTH-1:0]     if_rdata;

    logic                      d_req;
    logic                      d_we;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_be;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [DATA_WIDTH-1:0]     d_rdata;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    // Core and memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port fixed-latency memory
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         key,
    mem_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q,     state_d;
    logic [LAT_W-1:0]      lat_q,       lat_d;
    logic [STV_W-1:0]      starve_q,    starve_d;
    logic                  sel_data_q,  sel_data_d;
    logic                  if_gnt_q,    if_gnt_d;
    logic                  d_gnt_q,     d_gnt_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  d_rvalid_q,  d_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]   mem_be_q,    mem_be_d;
    logic                  fetch_wins;

    assign fetch_wins = bus.if_req && (!bus.d_req || (starve_q == STV_MAX));

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        sel_data_d  = sel_data_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE, RESP: begin
                if (bus.if_req || bus.d_req) begin
                    state_d    = ISSUE;
                    mem_en_d   = 1'b1;
                    sel_data_d = !fetch_wins;
                    if (fetch_wins) begin
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                        starve_d    = '0;
                    end else begin
                        d_gnt_d     = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_be_d    = bus.d_be;
                        // Only a data win over a waiting fetch counts toward starvation
                        if (!bus.if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STV_MAX) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end else begin
                    state_d  = IDLE;
                    starve_d = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_LAST;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                    if (sel_data_q) begin
                        d_rvalid_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge key) begin
        if (!key) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            sel_data_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            sel_data_q  <= sel_data_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SLIM = 4;

    logic clk = 1'b0;
    logic key;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk),
        .key(key),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mval;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic [31:0] e_other;
    } vec_t;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory environment: fixed-latency read pipe, writes applied on the access cycle
    logic [31:0] env_mem [logic [31:0]];
    logic [32:0] dly [0:LAT] = '{default: '0};

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < LAT; i++) dly[i] = dly[i+1];
        dly[LAT] = '0;
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we)
                env_mem[bus.mem_addr] = merge(env_rd(bus.mem_addr), bus.mem_wdata, bus.mem_be);
            else
                dly[LAT] = {1'b1, env_rd(bus.mem_addr)};
        end
        bus.mem_rdata = dly[0][32] ? dly[0][31:0] : $urandom;
    end

    // Reference model state for the randomized phase
    logic [31:0] ref_mem [logic [31:0]];
    int          next_arb, starve_m, if_gcyc, d_gcyc, g_cyc, r_cyc;
    logic        if_pend, d_pend, if_done, d_done, fw;
    logic        g_data, g_we;
    logic [31:0] g_addr, g_wdata, g_rdata, e_if_rd, e_d_rd;
    logic [3:0]  g_be;
    logic [31:0] m_if_addr, m_d_addr, m_d_wdata;
    logic        m_d_we;
    logic [3:0]  m_d_be;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_if_gnt"},    bus.if_gnt,    0);
        chk({nm, "_d_gnt"},     bus.d_gnt,     0);
        chk({nm, "_mem_en"},    bus.mem_en,    0);
        chk({nm, "_if_rvalid"}, bus.if_rvalid, 0);
        chk({nm, "_d_rvalid"},  bus.d_rvalid,  0);
        chk({nm, "_mem_we"},    bus.mem_we,    0);
        chk({nm, "_mem_addr"},  bus.mem_addr,  0);
        chk({nm, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({nm, "_mem_be"},    bus.mem_be,    0);
        chk({nm, "_if_rdata"},  bus.if_rdata,  0);
        chk({nm, "_d_rdata"},   bus.d_rdata,   0);
    endtask

    task automatic reset_mid(input int pc, input logic [31:0] a);
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        for (int c = 1; c <= pc; c++) begin
            @(negedge clk);
            if (c == 2) bus.if_req = 1'b0;
        end
        key = 1'b0;
        #1;
        bus.if_req = 1'b0;
        chk("rmid_mem_en",    bus.mem_en,    0);
        chk("rmid_if_gnt",    bus.if_gnt,    0);
        chk("rmid_if_rvalid", bus.if_rvalid, 0);
        chk("rmid_mem_addr",  bus.mem_addr,  0);
        chk("rmid_if_rdata",  bus.if_rdata,  0);
        @(negedge clk);
        key = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rmid_post_rvalid", bus.if_rvalid, 0);
            chk("rmid_post_mem_en", bus.mem_en,    0);
        end
        bus.if_req  = 1'b1;
        bus.if_addr = a + 32'h4;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("rmid_new_if_gnt", bus.if_gnt,    c == 1);
            chk("rmid_new_mem_en", bus.mem_en,    c == 1);
            chk("rmid_new_rvalid", bus.if_rvalid, c == 4);
            if (c == 2) bus.if_req = 1'b0;
        end
        chk("rmid_new_rdata", bus.if_rdata, init_word(a + 32'h4));
    endtask

    initial begin
        vec_t vt [5];
        vt[0] = '{is_d:1'b0, we:1'b0, addr:32'h10, wdata:32'h0, be:4'h0, mval:32'hDEADBEEF,
                  e_we:1'b0, e_be:4'hF, e_wdata:32'h0, e_rdata:32'hDEADBEEF, e_other:32'h0};
        vt[1] = '{is_d:1'b1, we:1'b1, addr:32'h20, wdata:32'h12345678, be:4'h3, mval:32'h0,
                  e_we:1'b1, e_be:4'h3, e_wdata:32'h12345678, e_rdata:32'h0, e_other:32'hDEADBEEF};
        vt[2] = '{is_d:1'b1, we:1'b0, addr:32'h30, wdata:32'h0BAD0BAD, be:4'hF, mval:32'hCAFEF00D,
                  e_we:1'b0, e_be:4'hF, e_wdata:32'h0BAD0BAD, e_rdata:32'hCAFEF00D, e_other:32'hDEADBEEF};
        vt[3] = '{is_d:1'b1, we:1'b1, addr:32'h34, wdata:32'hAABBCCDD, be:4'hC, mval:32'h0,
                  e_we:1'b1, e_be:4'hC, e_wdata:32'hAABBCCDD, e_rdata:32'hCAFEF00D, e_other:32'hDEADBEEF};
        vt[4] = '{is_d:1'b0, we:1'b0, addr:32'h44, wdata:32'h0, be:4'h0, mval:32'h01020304,
                  e_we:1'b0, e_be:4'hF, e_wdata:32'h0, e_rdata:32'h01020304, e_other:32'hCAFEF00D};

        // Reset held with both requests high
        key = 1'b0;
        idle_inputs();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h104;
        repeat (5) begin
            @(negedge clk);
            check_all_zero("rst");
        end
        idle_inputs();
        @(negedge clk);
        key = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("rst_release_mem_en", bus.mem_en, 0);
        end

        // Single transactions from idle
        for (int k = 0; k < 5; k++) begin
            env_mem[vt[k].addr] = vt[k].mval;
            @(negedge clk);
            if (vt[k].is_d) begin
                bus.d_req   = 1'b1;
                bus.d_we    = vt[k].we;
                bus.d_addr  = vt[k].addr;
                bus.d_wdata = vt[k].wdata;
                bus.d_be    = vt[k].be;
            end else begin
                bus.if_req  = 1'b1;
                bus.if_addr = vt[k].addr;
            end
            @(negedge clk);
            chk("tv_if_gnt",    bus.if_gnt,    !vt[k].is_d);
            chk("tv_d_gnt",     bus.d_gnt,     vt[k].is_d);
            chk("tv_mem_en",    bus.mem_en,    1);
            chk("tv_mem_addr",  bus.mem_addr,  vt[k].addr);
            chk("tv_mem_we",    bus.mem_we,    vt[k].e_we);
            chk("tv_mem_be",    bus.mem_be,    vt[k].e_be);
            chk("tv_mem_wdata", bus.mem_wdata, vt[k].e_wdata);
            @(negedge clk);
            idle_inputs();
            chk("tv_mem_en_off", bus.mem_en, 0);
            @(negedge clk);
            chk("tv_early_rvalid", bus.if_rvalid | bus.d_rvalid, 0);
            @(negedge clk);
            chk("tv_if_rvalid", bus.if_rvalid, !vt[k].is_d);
            chk("tv_d_rvalid",  bus.d_rvalid,  vt[k].is_d);
            chk("tv_win_rdata",   vt[k].is_d ? bus.d_rdata : bus.if_rdata, vt[k].e_rdata);
            chk("tv_other_rdata", vt[k].is_d ? bus.if_rdata : bus.d_rdata, vt[k].e_other);
        end

        // Simultaneous requests: data first, fetch right after
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h50;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h60;
        bus.d_be    = 4'hF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("sim_d_gnt",     bus.d_gnt,     c == 1);
            chk("sim_if_gnt",    bus.if_gnt,    c == 5);
            chk("sim_d_rvalid",  bus.d_rvalid,  c == 4);
            chk("sim_if_rvalid", bus.if_rvalid, c == 8);
            if (c == 2) bus.d_req = 1'b0;
            if (c == 6) bus.if_req = 1'b0;
        end
        chk("sim_if_rdata", bus.if_rdata, init_word(32'h50));
        chk("sim_d_rdata",  bus.d_rdata,  init_word(32'h60));

        // Starvation: both held high, every fifth grant goes to fetch
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h90;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("stv_d_gnt",  bus.d_gnt,  ((c - 1) % 4 == 0) && (((c - 1) / 4) % 5 != 4));
            chk("stv_if_gnt", bus.if_gnt, ((c - 1) % 4 == 0) && (((c - 1) / 4) % 5 == 4));
        end
        idle_inputs();
        repeat (4) @(negedge clk);

        reset_mid(1, 32'h700);
        reset_mid(3, 32'h710);
        reset_mid(4, 32'h720);

        // Randomized traffic against the transaction-slot model
        key = 1'b0;
        idle_inputs();
        @(negedge clk);
        key = 1'b1;
        next_arb = 0; starve_m = 0; if_gcyc = -10; d_gcyc = -10; g_cyc = -1; r_cyc = -1;
        if_pend = 0; d_pend = 0; if_done = 0; d_done = 0;
        g_data = 0; g_we = 0; g_addr = 0; g_wdata = 0; g_rdata = 0; g_be = 0;
        e_if_rd = 0; e_d_rd = 0;
        m_if_addr = 0; m_d_addr = 0; m_d_wdata = 0; m_d_we = 0; m_d_be = 0;
        for (int rc = 0; rc < 600; rc++) begin
            chk("rnd_if_gnt", bus.if_gnt, (g_cyc == rc) && !g_data);
            chk("rnd_d_gnt",  bus.d_gnt,  (g_cyc == rc) && g_data);
            chk("rnd_mem_en", bus.mem_en, g_cyc == rc);
            if (g_cyc == rc) begin
                chk("rnd_mem_addr",  bus.mem_addr,  g_addr);
                chk("rnd_mem_we",    bus.mem_we,    g_we);
                chk("rnd_mem_be",    bus.mem_be,    g_be);
                chk("rnd_mem_wdata", bus.mem_wdata, g_wdata);
            end
            if (r_cyc == rc && !g_we) begin
                if (g_data) e_d_rd = g_rdata;
                else        e_if_rd = g_rdata;
            end
            chk("rnd_if_rvalid", bus.if_rvalid, (r_cyc == rc) && !g_data);
            chk("rnd_d_rvalid",  bus.d_rvalid,  (r_cyc == rc) && g_data);
            chk("rnd_if_rdata",  bus.if_rdata,  e_if_rd);
            chk("rnd_d_rdata",   bus.d_rdata,   e_d_rd);

            if (if_done && rc > if_gcyc) begin if_pend = 0; if_done = 0; end
            if (d_done && rc > d_gcyc) begin d_pend = 0; d_done = 0; end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend   = 1;
                m_if_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend    = 1;
                m_d_we    = 1'($urandom_range(0, 1));
                m_d_addr  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                m_d_wdata = $urandom;
                m_d_be    = 4'($urandom_range(0, 15));
            end
            bus.if_req  = if_pend;
            bus.if_addr = m_if_addr;
            bus.d_req   = d_pend;
            bus.d_we    = m_d_we;
            bus.d_addr  = m_d_addr;
            bus.d_wdata = m_d_wdata;
            bus.d_be    = m_d_be;

            if (rc >= next_arb) begin
                if (if_pend || d_pend) begin
                    fw = if_pend && (!d_pend || starve_m == SLIM);
                    if (fw || !if_pend) starve_m = 0;
                    else if (starve_m < SLIM) starve_m = starve_m + 1;
                    g_data   = !fw;
                    g_cyc    = rc + 1;
                    r_cyc    = rc + 2 + LAT;
                    next_arb = r_cyc;
                    if (fw) begin
                        g_addr = m_if_addr; g_we = 0; g_be = 4'hF; g_wdata = 0;
                        g_rdata = ref_rd(g_addr);
                        if_done = 1; if_gcyc = rc + 1;
                    end else begin
                        g_addr = m_d_addr; g_we = m_d_we; g_be = m_d_be; g_wdata = m_d_wdata;
                        if (g_we) ref_mem[g_addr] = merge(ref_rd(g_addr), g_wdata, g_be);
                        else      g_rdata = ref_rd(g_addr);
                        d_done = 1; d_gcyc = rc + 1;
                    end
                end else begin
                    next_arb = rc + 1;
                    starve_m = 0;
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the CPU's single-port memory between the instruction-fetch path and the load/store path. It accepts one request at a time, drives one memory access, waits the fixed memory latency and returns the read data or write acknowledge to the winning requester. Data accesses have priority, and a starvation counter bounds how long fetch can wait. It sits inside `top` between the core and the memory.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports.
- `DATA_WIDTH`, 32, data width. Byte enables are `DATA_WIDTH/8` bits wide.
- `MEM_LATENCY`, 2, number of cycles from the `mem_en` cycle to the cycle in which `mem_rdata` is valid. Must be ≥1.
- `STARVE_LIMIT`, 4, number of consecutive data wins over a pending fetch before fetch is forced to win. Must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `key`  in  1  reset; asynchronous, active-low.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_gnt`  out  1  one-cycle pulse: fetch request accepted.
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` is valid.
- `if_rdata`  out  DATA_WIDTH  fetch read data.
- `d_req`  in  1  data request; held with attributes until `d_gnt`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_be`  in  DATA_WIDTH/8  byte enables.
- `d_gnt`  out  1  one-cycle pulse: data request accepted.
- `d_rvalid`  out  1  one-cycle pulse: read data valid, or write completed.
- `d_rdata`  out  DATA_WIDTH  data read data.
- `mem_en`  out  1  memory access strobe, one cycle.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_be`  out  DATA_WIDTH/8  memory byte enables.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid `MEM_LATENCY` cycles after the `mem_en` cycle.

## Operation
- States:
  - IDLE: no transaction in flight.
  - ISSUE: access is on the memory bus.
  - WAIT: latency counter is running.
  - RESP: response is being returned.
- All outputs are registered or decoded from state and latched registers. No combinational path runs from any `*_req` input to any output.
- Arbitration happens only in IDLE and RESP:
  - If no request is present, go to (or stay in) IDLE.
  - Otherwise latch the winner's attributes and go to ISSUE.
- Winner selection:
  - If both requests are present, data wins, unless the starvation counter equals `STARVE_LIMIT`; then fetch wins.
  - A single request always wins.
- Starvation counter:
  - Increments on each arbitration where `if_req` is high and data wins.
  - Clears when fetch wins, or at any arbitration where `if_req` is low.
  - Saturates at `STARVE_LIMIT`.
- ISSUE lasts one cycle:
  - `mem_en` = 1.
  - The winner's `*_gnt` = 1.
  - For fetch: `mem_we` = 0, `mem_be` = all ones, `mem_wdata` = 0.
  - For data: `mem_we`, `mem_be` and `mem_wdata` take the latched `d_*` values.
- WAIT lasts `MEM_LATENCY` cycles, counting down. In the last WAIT cycle, `mem_rdata` is captured into the winner's rdata register, for reads only. Writes leave `d_rdata` unchanged. The loser's rdata always holds its value.
- RESP lasts one cycle: the winner's `*_rvalid` = 1. `d_rvalid` pulses for writes too.
- Requests present during ISSUE or WAIT are ignored until the next arbitration point.
- Outside ISSUE, `mem_addr`, `mem_wdata`, `mem_be` and `mem_we` hold their last values, and `mem_en` = 0.
- Reset (`key` low):
  - State goes to IDLE and the counters clear.
  - Every output goes to 0 immediately, including the rdata registers.
  - Any in-flight transaction is dropped; no `rvalid` is produced for it after release.

## Timing
- Request seen in cycle T (arbiter in IDLE or RESP):
  - ISSUE in T+1, with `gnt` and `mem_en`.
  - WAIT in T+2 … T+1+`MEM_LATENCY`.
  - RESP (`rvalid`) in T+2+`MEM_LATENCY`.
- Back-to-back throughput: one transaction per `MEM_LATENCY`+2 cycles. The next ISSUE may occur in the cycle after RESP.
- A requester drops or changes `req` after the edge that ends its `gnt` cycle. A `req` still high during ISSUE is not re-counted.
- `mem_rdata` is sampled at the rising edge that ends cycle T+1+`MEM_LATENCY`.

## Test plan
- **Reset:** hold `key` low for 5 cycles with both requests high → every output is 0, with no `gnt` or `mem_en`. Release with no requests → `mem_en` stays 0 for 10 cycles.
- **Fetch read (`MEM_LATENCY`=2):** `if_req` with `if_addr`=0x10 in cycle 0, memory returns 0xDEADBEEF → in cycle 1, `if_gnt`=1, `mem_en`=1, `mem_addr`=0x10, `mem_we`=0, `mem_be`=0xF. In cycle 4, `if_rvalid`=1 and `if_rdata`=0xDEADBEEF.
- **Data write:** `d_req`, `d_we`=1, `d_addr`=0x20, `d_wdata`=0x12345678, `d_be`=0x3 → in cycle 1, `mem_en`=1 and `mem_we`=1 with those values. In cycle 4, `d_rvalid`=1 and `d_rdata` is unchanged.
- **Simultaneous requests:** `if_req` and `d_req` both rise in cycle 0 → `d_gnt` in cycle 1 and `d_rvalid` in cycle 4. `if_gnt` in cycle 5 and `if_rvalid` in cycle 8.
- **Starvation (`STARVE_LIMIT`=4):** `d_req` and `if_req` held high continuously → the first 4 grants go to data and the 5th goes to fetch. After that, the counter restarts and data wins the next 4.
- **Reset mid-WAIT:** pulse `key` low during WAIT → `mem_en` and `rvalid` drop immediately, and no `rvalid` appears after release. A new `if_req` after release completes with standard timing.
